// File: rtl/frame_sync_cmd_pkg.sv
// Shared types for the frame-synchronised configuration command scheduler.
package frame_sync_cmd_pkg;

  localparam int ADDR_WIDTH = 16;
  localparam int DATA_WIDTH = 32;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    DRAIN = 1'b1
  } sched_state_t;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] data;
  } cmd_t;

endpackage

// File: rtl/cmd_fifo.sv
// Synchronous FIFO of configuration commands. Pointers and occupancy reset
// asynchronously; the storage array is left unreset because a cleared count
// makes any stale contents unreachable.
module cmd_fifo
  import frame_sync_cmd_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                       clk_i,
  input  logic                       rst_n_i,
  input  logic                       push_i,
  input  cmd_t                       wdata_i,
  input  logic                       pop_i,
  output cmd_t                       rdata_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o,
  output logic                       full_o,
  output logic                       empty_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  cmd_t            r_mem [DEPTH];
  logic [PW-1:0]   r_wr_ptr;
  logic [PW-1:0]   r_rd_ptr;
  logic [CW-1:0]   r_count;
  logic            w_do_push;
  logic            w_do_pop;

  assign full_o    = (r_count == CW'(DEPTH));
  assign empty_o   = (r_count == '0);
  assign w_do_push = push_i && !full_o;
  assign w_do_pop  = pop_i && !empty_o;
  assign rdata_o   = r_mem[r_rd_ptr];
  assign count_o   = r_count;

  // Storage write; DEPTH is a power of two so pointers wrap naturally.
  always_ff @(posedge clk_i) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= wdata_i;
    end
  end

  // Pointer and occupancy tracking; push and pop together leave count as is.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      if (w_do_push && !w_do_pop) begin
        r_count <= r_count + CW'(1);
      end else if (w_do_pop && !w_do_push) begin
        r_count <= r_count - CW'(1);
      end
    end
  end

endmodule

// File: rtl/frame_sync_cmd_scheduler.sv
// Holds host configuration writes in a FIFO and releases them to the
// configuration register block only at frame boundaries (or continuously in
// immediate mode). Each drain releases exactly the entries present when it
// started, so writes landing mid-drain wait for the next boundary.
module frame_sync_cmd_scheduler #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 16
) (
  input  logic                        clk_i,
  input  logic                        rst_n_i,
  input  logic                        up_valid_i,
  output logic                        up_ready_o,
  input  logic [ADDR_WIDTH-1:0]       up_addr_i,
  input  logic [DATA_WIDTH-1:0]       up_data_i,
  input  logic                        frame_end_i,
  input  logic                        immediate_i,
  output logic                        dn_valid_o,
  output logic [ADDR_WIDTH-1:0]       dn_addr_o,
  output logic [DATA_WIDTH-1:0]       dn_data_o,
  output logic [$clog2(DEPTH+1)-1:0]  pending_o,
  output logic                        busy_o
);

  import frame_sync_cmd_pkg::cmd_t;
  import frame_sync_cmd_pkg::sched_state_t;
  import frame_sync_cmd_pkg::IDLE;
  import frame_sync_cmd_pkg::DRAIN;

  localparam int CW = $clog2(DEPTH+1);

  sched_state_t           r_state;
  sched_state_t           w_state_nxt;
  logic [CW-1:0]          r_quota;
  logic                   r_deferred;
  logic                   r_dn_valid;
  logic [ADDR_WIDTH-1:0]  r_dn_addr;
  logic [DATA_WIDTH-1:0]  r_dn_data;

  logic                   w_push;
  logic                   w_pop;
  logic                   w_start;
  logic [CW-1:0]          w_count;
  logic                   w_full;
  logic                   w_empty;
  cmd_t                   w_wr_cmd;
  cmd_t                   w_rd_cmd;

  assign up_ready_o = !w_full;
  assign w_push     = up_valid_i && up_ready_o;
  assign w_pop      = (r_state == DRAIN) && (r_quota != '0);
  assign w_wr_cmd   = '{addr: up_addr_i, data: up_data_i};

  cmd_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .push_i  (w_push),
    .wdata_i (w_wr_cmd),
    .pop_i   (w_pop),
    .rdata_o (w_rd_cmd),
    .count_o (w_count),
    .full_o  (w_full),
    .empty_o (w_empty)
  );

  // Next-state: start a drain on any trigger when work is queued; leave
  // DRAIN on the pop that exhausts the snapshot quota.
  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    case (r_state)
      IDLE: begin
        if ((frame_end_i || r_deferred || immediate_i) && !w_empty) begin
          w_state_nxt = DRAIN;
          w_start     = 1'b1;
        end
      end
      DRAIN: begin
        if (r_quota == CW'(1)) begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Quota snapshot at drain entry; a boundary seen mid-drain is remembered.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_quota    <= '0;
      r_deferred <= 1'b0;
    end else begin
      if (w_start) begin
        r_quota    <= w_count;
        r_deferred <= 1'b0;
      end else begin
        if (w_pop) begin
          r_quota <= r_quota - CW'(1);
        end
        if ((r_state == DRAIN) && frame_end_i) begin
          r_deferred <= 1'b1;
        end
      end
    end
  end

  // Output register: strobe per pop, address/data hold between strobes.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_dn_valid <= 1'b0;
      r_dn_addr  <= '0;
      r_dn_data  <= '0;
    end else begin
      r_dn_valid <= w_pop;
      if (w_pop) begin
        r_dn_addr <= w_rd_cmd.addr;
        r_dn_data <= w_rd_cmd.data;
      end
    end
  end

  assign dn_valid_o = r_dn_valid;
  assign dn_addr_o  = r_dn_addr;
  assign dn_data_o  = r_dn_data;
  assign pending_o  = w_count;
  assign busy_o     = (r_state == DRAIN);

endmodule

// File: tb/tb_frame_sync_cmd_scheduler.sv
// Scoreboard bench for frame_sync_cmd_scheduler: accepted writes are queued
// as expected strobes, a negedge monitor pops and compares each strobe.
module tb_frame_sync_cmd_scheduler;

  logic        clk_i = 1'b0;
  logic        rst_n_i = 1'b0;
  logic        up_valid_i = 1'b0;
  logic        up_ready_o;
  logic [15:0] up_addr_i = '0;
  logic [31:0] up_data_i = '0;
  logic        frame_end_i = 1'b0;
  logic        immediate_i = 1'b0;
  logic        dn_valid_o;
  logic [15:0] dn_addr_o;
  logic [31:0] dn_data_o;
  logic [4:0]  pending_o;
  logic        busy_o;

  frame_sync_cmd_scheduler #(
    .ADDR_WIDTH (16),
    .DATA_WIDTH (32),
    .DEPTH      (16)
  ) dut (
    .clk_i       (clk_i),
    .rst_n_i     (rst_n_i),
    .up_valid_i  (up_valid_i),
    .up_ready_o  (up_ready_o),
    .up_addr_i   (up_addr_i),
    .up_data_i   (up_data_i),
    .frame_end_i (frame_end_i),
    .immediate_i (immediate_i),
    .dn_valid_o  (dn_valid_o),
    .dn_addr_o   (dn_addr_o),
    .dn_data_o   (dn_data_o),
    .pending_o   (pending_o),
    .busy_o      (busy_o)
  );

  always #5 clk_i = ~clk_i;

  logic [47:0] sb[$];
  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int strobes = 0;
  int first_strobe_cyc = -1;

  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every strobe must match the oldest expected write.
  always @(negedge clk_i) begin
    if (dn_valid_o === 1'b1) begin
      strobes++;
      if (first_strobe_cyc < 0) first_strobe_cyc = cyc;
      if (sb.size() == 0) begin
        chk("unexpected_strobe", {16'h0, dn_addr_o, dn_data_o}, 64'hDEAD);
      end else begin
        chk("strobe_cmd", {16'h0, dn_addr_o, dn_data_o}, {16'h0, sb.pop_front()});
      end
    end
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic push(input logic [15:0] a, input logic [31:0] d);
    int n;
    logic acc;
    n = 0;
    up_valid_i = 1'b1;
    up_addr_i  = a;
    up_data_i  = d;
    do begin
      acc = up_ready_o;
      tick();
      n++;
    end while (!acc && n < 100);
    up_valid_i = 1'b0;
    if (acc) sb.push_back({a, d});
    else chk("push_accept_timeout", 64'(acc), 64'd1);
  endtask

  task automatic pulse_frame(output int edge_cyc);
    frame_end_i = 1'b1;
    tick();
    edge_cyc = cyc;
    frame_end_i = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((sb.size() != 0 || busy_o) && n < 300) begin
      tick();
      n++;
    end
    if (n >= 300) chk("drain_timeout", 64'(sb.size()), 64'd0);
    tick();
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout: got time %0t expected completion", $time);
    $fatal(1, "timeout");
  end

  initial begin
    int s0;
    int pe;
    int pc;
    // Reset state
    #3;
    chk("rst_up_ready", 64'(up_ready_o), 64'd1);
    chk("rst_dn_valid", 64'(dn_valid_o), 64'd0);
    chk("rst_dn_addr", 64'(dn_addr_o), 64'd0);
    chk("rst_dn_data", 64'(dn_data_o), 64'd0);
    chk("rst_pending", 64'(pending_o), 64'd0);
    chk("rst_busy", 64'(busy_o), 64'd0);
    repeat (2) tick();
    @(negedge clk_i);
    rst_n_i = 1'b1;
    repeat (2) tick();

    // 1: three writes held until the boundary
    s0 = strobes;
    push(16'h0010, 32'h100);
    push(16'h0011, 32'h0);
    push(16'h0060, 32'hC8);
    repeat (4) tick();
    chk("t1_no_strobe", 64'(strobes - s0), 64'd0);
    chk("t1_pending3", 64'(pending_o), 64'd3);
    first_strobe_cyc = -1;
    pulse_frame(pe);
    chk("t1_busy_after_pulse", 64'(busy_o), 64'd1);
    wait_idle();
    chk("t1_first_latency", 64'(first_strobe_cyc - pe), 64'd1);
    chk("t1_strobes", 64'(strobes - s0), 64'd3);
    chk("t1_pending0", 64'(pending_o), 64'd0);
    chk("t1_hold_addr", 64'(dn_addr_o), 64'h60);
    chk("t1_hold_data", 64'(dn_data_o), 64'hC8);

    // 2: fill to full, 17th held off until first pop
    s0 = strobes;
    for (int i = 0; i < 16; i++) push(16'h0100 + 16'(i), 32'h5000 + 32'(i * 3));
    chk("t2_full_ready", 64'(up_ready_o), 64'd0);
    chk("t2_pending16", 64'(pending_o), 64'd16);
    up_valid_i = 1'b1;
    up_addr_i  = 16'h0200;
    up_data_i  = 32'hABCD;
    repeat (3) tick();
    chk("t2_held_ready", 64'(up_ready_o), 64'd0);
    chk("t2_held_pending", 64'(pending_o), 64'd16);
    pulse_frame(pe);
    chk("t2_ready_before_pop", 64'(up_ready_o), 64'd0);
    tick();
    chk("t2_ready_after_pop", 64'(up_ready_o), 64'd1);
    tick();
    up_valid_i = 1'b0;
    sb.push_back({16'h0200, 32'hABCD});
    repeat (20) tick();
    chk("t2_strobes16", 64'(strobes - s0), 64'd16);
    chk("t2_pending1", 64'(pending_o), 64'd1);
    pulse_frame(pe);
    wait_idle();
    chk("t2_strobes17", 64'(strobes - s0), 64'd17);

    // 3a: boundary during drain is deferred
    s0 = strobes;
    for (int i = 0; i < 4; i++) push(16'h0300 + 16'(i), 32'h700 + 32'(i));
    pulse_frame(pe);
    up_valid_i = 1'b1; up_addr_i = 16'h0310; up_data_i = 32'h11;
    tick();
    sb.push_back({16'h0310, 32'h11});
    up_addr_i = 16'h0311; up_data_i = 32'h22;
    tick();
    sb.push_back({16'h0311, 32'h22});
    up_valid_i = 1'b0;
    frame_end_i = 1'b1;
    tick();
    frame_end_i = 1'b0;
    wait_idle();
    chk("t3_deferred_strobes", 64'(strobes - s0), 64'd6);
    chk("t3_deferred_pending", 64'(pending_o), 64'd0);

    // 3b: no second boundary, late writes stay queued
    s0 = strobes;
    for (int i = 0; i < 4; i++) push(16'h0400 + 16'(i), 32'h900 + 32'(i));
    pulse_frame(pe);
    up_valid_i = 1'b1; up_addr_i = 16'h0410; up_data_i = 32'h33;
    tick();
    sb.push_back({16'h0410, 32'h33});
    up_addr_i = 16'h0411; up_data_i = 32'h44;
    tick();
    sb.push_back({16'h0411, 32'h44});
    up_valid_i = 1'b0;
    repeat (10) tick();
    chk("t3b_strobes4", 64'(strobes - s0), 64'd4);
    chk("t3b_pending2", 64'(pending_o), 64'd2);
    chk("t3b_busy", 64'(busy_o), 64'd0);
    pulse_frame(pe);
    wait_idle();
    chk("t3b_flush", 64'(strobes - s0), 64'd6);

    // 4: immediate mode streaming
    s0 = strobes;
    immediate_i = 1'b1;
    tick();
    first_strobe_cyc = -1;
    up_valid_i = 1'b1;
    pc = -1;
    for (int i = 0; i < 20; i++) begin
      up_addr_i = 16'h0800 + 16'(i);
      up_data_i = 32'hC000 + 32'(i * 7);
      chk("t4_ready", 64'(up_ready_o), 64'd1);
      tick();
      if (pc < 0) pc = cyc;
      sb.push_back({up_addr_i, up_data_i});
    end
    up_valid_i = 1'b0;
    wait_idle();
    chk("t4_strobes20", 64'(strobes - s0), 64'd20);
    chk("t4_latency", 64'(first_strobe_cyc - pc), 64'd2);
    immediate_i = 1'b0;
    tick();

    // 5: reset asserted mid-drain after 2 of 5 strobes
    s0 = strobes;
    for (int i = 0; i < 5; i++) push(16'h0900 + 16'(i), 32'hE00 + 32'(i));
    pulse_frame(pe);
    tick();
    tick();
    @(negedge clk_i);
    #1;
    rst_n_i = 1'b0;
    #1;
    chk("t5_dn_valid_drop", 64'(dn_valid_o), 64'd0);
    chk("t5_pending0", 64'(pending_o), 64'd0);
    chk("t5_busy0", 64'(busy_o), 64'd0);
    chk("t5_ready1", 64'(up_ready_o), 64'd1);
    chk("t5_two_sent", 64'(strobes - s0), 64'd2);
    sb.delete();
    tick();
    @(negedge clk_i);
    rst_n_i = 1'b1;
    tick();
    s0 = strobes;
    pulse_frame(pe);
    repeat (8) tick();
    chk("t5_no_strobes", 64'(strobes - s0), 64'd0);
    chk("t5_busy_after", 64'(busy_o), 64'd0);

    // 6: same-address writes both emitted in order
    s0 = strobes;
    push(16'h00A0, 32'h3C00);
    push(16'h00A0, 32'h4000);
    pulse_frame(pe);
    wait_idle();
    chk("t6_strobes2", 64'(strobes - s0), 64'd2);
    chk("t6_last_data", 64'(dn_data_o), 64'h4000);

    repeat (3) tick();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
